// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Opcode constants are for the upstream decoder that produces id_is_load and the branch flags.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int REG_AW_MAX = 8;

  // Destinations are stored at REG_AW_MAX bits so one slot type serves every REG_AW build
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  we;
    logic                  is_load;
  } slot_t;

  function automatic int fwd_w(input int nslot);
    return $clog2(nslot + 1);
  endfunction

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/hazard_fwd_pick.sv
// Youngest-match priority encoder for one source operand against the in-flight slots.
// sel = k+1 for the smallest matching slot k, 0 when the register file holds the value.
module hazard_fwd_pick
  import hazard_pkg::*;
#(
  parameter int NSLOT  = 3,
  parameter int REG_AW = REG_AW_DEF,
  parameter int FW     = fwd_w(NSLOT)
) (
  input  slot_t [NSLOT-1:0] slots,
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  output logic [NSLOT-1:0]  hit,
  output logic [FW-1:0]     sel
);

  always_comb begin
    hit = '0;
    sel = '0;
    // Walk oldest to youngest so the youngest match overwrites sel last
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (slots[k].valid && slots[k].we && (slots[k].rd == REG_AW_MAX'(rs)) &&
          (rs != '0) && rs_used) begin
        hit[k] = 1'b1;
        sel    = FW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: per-stage destination scoreboard, load-use stall,
// taken-branch flush/squash, registered forward selects and saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int REG_AW    = REG_AW_DEF,
  parameter  int NSLOT     = 3,
  parameter  int BR_STAGE  = 1,
  parameter  int LOAD_SLOT = 2,
  parameter  int CNT_W     = 32,
  localparam int FW        = fwd_w(NSLOT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush_id,
  output logic [BR_STAGE-1:0] squash,
  output logic [FW-1:0]     fwd_rs1,
  output logic [FW-1:0]     fwd_rs2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (!((LOAD_SLOT >= 1) && (LOAD_SLOT < NSLOT) && (BR_STAGE >= 1) &&
        (BR_STAGE < NSLOT) && (REG_AW <= REG_AW_MAX))) begin : g_param_check
    $error("hazard_ctrl: illegal LOAD_SLOT/BR_STAGE/NSLOT/REG_AW combination");
  end

  // Slots whose load result is not yet forwardable when the ID op reaches EX
  localparam logic [NSLOT-1:0] LU_MASK = NSLOT'((64'd1 << (LOAD_SLOT - 1)) - 64'd1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  slot_t [NSLOT-1:0] slot_p1;
  slot_t             id_entry;
  logic [NSLOT-1:0]  hit1, hit2, load_vec;
  logic [FW-1:0]     sel1, sel2;
  logic              enter;

  hazard_fwd_pick #(.NSLOT(NSLOT), .REG_AW(REG_AW), .FW(FW)) u_pick_rs1 (
    .slots(slot_p1), .rs(id_rs1), .rs_used(id_rs1_used), .hit(hit1), .sel(sel1)
  );

  hazard_fwd_pick #(.NSLOT(NSLOT), .REG_AW(REG_AW), .FW(FW)) u_pick_rs2 (
    .slots(slot_p1), .rs(id_rs2), .rs_used(id_rs2_used), .hit(hit2), .sel(sel2)
  );

  always_comb begin
    load_vec = '0;
    for (int k = 0; k < NSLOT; k++) load_vec[k] = slot_p1[k].is_load;
  end

  // A taken branch always wins over a load-use stall
  assign stall    = rst & id_valid & ~br_taken & (|((hit1 | hit2) & load_vec & LU_MASK));
  assign flush_id = rst & br_taken;
  assign squash   = {BR_STAGE{rst & br_taken}};
  assign enter    = id_valid & ~stall & ~br_taken;

  always_comb begin
    id_entry = '0;
    if (enter) begin
      id_entry.valid   = 1'b1;
      id_entry.rd      = REG_AW_MAX'(id_rd);
      id_entry.we      = id_rd_we;
      id_entry.is_load = id_is_load;
    end
  end

  // ---- ID -> slot0 boundary; slots shift unconditionally, squashed ones become bubbles ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_p1   <= '0;
      fwd_rs1   <= '0;
      fwd_rs2   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      slot_p1[0] <= id_entry;
      for (int k = 1; k < NSLOT; k++) begin
        slot_p1[k] <= (br_taken && ((k - 1) < BR_STAGE)) ? '0 : slot_p1[k-1];
      end
      fwd_rs1 <= enter ? sel1 : '0;
      fwd_rs2 <= enter ? sel2 : '0;
      if (stall)    stall_cnt <= sat_inc(stall_cnt);
      if (br_taken) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus a BR_STAGE=2 / CNT_W=4 build.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall, flush_id;
  logic [0:0]  squash;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic [31:0] stall_cnt, flush_cnt;

  logic        a_stall, a_flush;
  logic [1:0]  a_squash, a_fwd1, a_fwd2;
  logic [3:0]  a_stall_cnt, a_flush_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .br_taken(br_taken), .stall(stall), .flush_id(flush_id),
    .squash(squash), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.BR_STAGE(2), .CNT_W(4)) u_alt (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .br_taken(br_taken), .stall(a_stall), .flush_id(a_flush),
    .squash(a_squash), .fwd_rs1(a_fwd1), .fwd_rs2(a_fwd2), .stall_cnt(a_stall_cnt),
    .flush_cnt(a_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we, ld, br;
    logic       e_stall, e_flush;
    logic [1:0] e_f1, e_f2;
  } vec_t;

  function automatic vec_t mk(input logic va, input logic [4:0] r1, input logic u1,
                              input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                              input logic we, input logic ld, input logic br,
                              input logic es, input logic ef,
                              input logic [1:0] f1, input logic [1:0] f2);
    vec_t v;
    v.valid = va; v.rs1 = r1; v.u1 = u1; v.rs2 = r2; v.u2 = u2; v.rd = rd;
    v.we = we; v.ld = ld; v.br = br; v.e_stall = es; v.e_flush = ef; v.e_f1 = f1; v.e_f2 = f2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_id(input logic va, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic br);
    id_valid = va; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; br_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input int idx);
    set_id(v.valid, v.rs1, v.u1, v.rs2, v.u2, v.rd, v.we, v.ld, v.br);
    #2;
    chk($sformatf("v%0d stall", idx), 32'(stall), 32'(v.e_stall));
    chk($sformatf("v%0d alt_stall", idx), 32'(a_stall), 32'(v.e_stall));
    chk($sformatf("v%0d flush_id", idx), 32'(flush_id), 32'(v.e_flush));
    chk($sformatf("v%0d squash", idx), 32'(squash), 32'(v.e_flush));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d fwd_rs1", idx), 32'(fwd_rs1), 32'(v.e_f1));
    chk($sformatf("v%0d fwd_rs2", idx), 32'(fwd_rs2), 32'(v.e_f2));
    @(negedge clk);
  endtask

  vec_t vecs [19];

  initial begin
    //             va rs1 u1 rs2 u2 rd we ld br  stl fl  f1 f2
    vecs[0]  = mk(1,  1, 1,  2, 1,  5, 1, 0, 0,  0, 0,  0, 0); // add x5
    vecs[1]  = mk(1,  5, 1,  3, 1,  6, 1, 0, 0,  0, 0,  1, 0); // add x6,x5 (gap 1)
    vecs[2]  = mk(1,  4, 1,  5, 1,  9, 1, 0, 0,  0, 0,  0, 2); // x5 gap 2 on rs2
    vecs[3]  = mk(1,  5, 1,  6, 1, 10, 1, 0, 0,  0, 0,  3, 2); // x5 in WB slot, x6 in MEM
    vecs[4]  = mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0);
    vecs[5]  = mk(1,  1, 1,  0, 0,  7, 1, 1, 0,  0, 0,  0, 0); // ld x7
    vecs[6]  = mk(1,  7, 1,  0, 1,  8, 1, 0, 0,  1, 0,  0, 0); // add x8,x7 -> stall
    vecs[7]  = mk(1,  7, 1,  0, 1,  8, 1, 0, 0,  0, 0,  2, 0); // retry, forwarded
    vecs[8]  = mk(1,  1, 1,  0, 0,  0, 1, 1, 0,  0, 0,  0, 0); // ld x0
    vecs[9]  = mk(1,  0, 1,  0, 1,  1, 1, 0, 0,  0, 0,  0, 0); // add x1,x0,x0
    vecs[10] = mk(1,  2, 1,  0, 0, 11, 1, 1, 0,  0, 0,  0, 0); // ld x11
    vecs[11] = mk(1,  3, 1, 11, 0, 12, 1, 0, 0,  0, 0,  0, 0); // rs2=x11 unused
    vecs[12] = mk(1, 11, 1,  1, 1, 13, 1, 0, 0,  0, 0,  2, 3); // load in MEM, x1 in WB
    vecs[13] = mk(1,  1, 1,  0, 0, 14, 1, 1, 0,  0, 0,  0, 0); // ld x14
    vecs[14] = mk(1, 14, 1,  0, 0, 15, 1, 0, 1,  0, 1,  0, 0); // load-use + branch
    vecs[15] = mk(1, 14, 1, 13, 1, 16, 1, 0, 0,  0, 0,  0, 3); // squashed x14 not forwarded
    vecs[16] = mk(1, 16, 1,  0, 0, 17, 1, 0, 1,  0, 1,  0, 0); // branch
    vecs[17] = mk(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 1,  0, 0); // back-to-back branch
    vecs[18] = mk(1, 16, 1,  0, 0, 18, 1, 0, 0,  0, 0,  0, 0); // x16 was squashed

    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst stall", 32'(stall), 0);
    chk("rst flush_id", 32'(flush_id), 0);
    chk("rst fwd_rs1", 32'(fwd_rs1), 0);
    chk("rst stall_cnt", stall_cnt, 0);
    tick();
    tick();
    rst = 1'b1;

    for (int i = 0; i < 19; i++) apply(vecs[i], i);

    chk("table stall_cnt", stall_cnt, 1);
    chk("table flush_cnt", flush_cnt, 3);
    chk("table alt_stall_cnt", 32'(a_stall_cnt), 1);
    chk("table alt_flush_cnt", 32'(a_flush_cnt), 3);

    // Asynchronous reset while slots hold a load-use hazard
    set_id(1, 1, 1, 0, 0, 5, 1, 0, 0);
    tick();
    set_id(1, 1, 1, 0, 0, 7, 1, 1, 0);
    tick();
    set_id(1, 7, 1, 0, 0, 8, 1, 0, 0);
    #2;
    chk("pre-reset stall", 32'(stall), 1);
    rst = 1'b0;
    br_taken = 1'b1;
    #1;
    chk("mid-rst stall", 32'(stall), 0);
    chk("mid-rst flush_id", 32'(flush_id), 0);
    chk("mid-rst squash", 32'(squash), 0);
    chk("mid-rst alt_squash", 32'(a_squash), 0);
    chk("mid-rst fwd_rs1", 32'(fwd_rs1), 0);
    chk("mid-rst fwd_rs2", 32'(fwd_rs2), 0);
    chk("mid-rst alt_fwd", 32'({a_fwd1, a_fwd2}), 0);
    chk("mid-rst stall_cnt", stall_cnt, 0);
    chk("mid-rst flush_cnt", flush_cnt, 0);
    chk("mid-rst alt_flush_cnt", 32'(a_flush_cnt), 0);
    tick();
    rst = 1'b1;
    set_id(1, 5, 1, 7, 1, 1, 1, 0, 0);
    #2;
    chk("post-rst stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    chk("post-rst fwd_rs1", 32'(fwd_rs1), 0);
    chk("post-rst fwd_rs2", 32'(fwd_rs2), 0);
    @(negedge clk);

    // ld x7,(x7) repeated: stalls every other cycle, 20 stalls in 40 cycles
    set_id(1, 7, 1, 0, 0, 7, 1, 1, 0);
    repeat (40) tick();
    chk("sat stall_cnt", stall_cnt, 20);
    chk("sat alt_stall_cnt", 32'(a_stall_cnt), 15);

    // Branch with BR_STAGE=2 squashes both younger slots
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("br squash", 32'(squash), 1);
    chk("br alt_squash", 32'(a_squash), 3);
    chk("br alt_flush", 32'(a_flush), 1);
    tick();
    br_taken = 1'b0;
    #1;
    chk("br flush_cnt", flush_cnt, 1);
    chk("br alt_flush_cnt", 32'(a_flush_cnt), 1);
    chk("br stall_cnt held", stall_cnt, 20);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
